// File: rtl/buf_seq.sv
// buf_seq: frame sequencer for the cubic transpose buffer between two FFT passes.
// Writes a cube in row/dep/col order, then reads it back transposed (row fastest).
// Ports:
//   clock, reset_n             clock and async active-low reset
//   in_valid/in_ready          upstream beat handshake (two samples per beat)
//   in_data0/1                 upstream sample pair (even, odd row)
//   out_valid/out_ready        downstream handshake on the output register
//   out_data0/1                registered buffer read data
//   frame_done                 one-cycle pulse after the last read of a cube
//   busy                       high while reading the cube back
//   buf_wr/buf_rd              buffer write and read strobes
//   buf_row/buf_col/buf_dep    buffer index (row counts row pairs)
//   buf_wrdata0/1              buffer write data
//   buf_rddata0/1              combinational buffer read data
module buf_seq #(
   parameter int CUBIC_D = 96
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data0,
   input  logic [63:0] in_data1,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_data0,
   output logic [63:0] out_data1,
   output logic        frame_done,
   output logic        busy,
   output logic        buf_wr,
   output logic        buf_rd,
   output logic [6:0]  buf_row,
   output logic [6:0]  buf_col,
   output logic [6:0]  buf_dep,
   output logic [63:0] buf_wrdata0,
   output logic [63:0] buf_wrdata1,
   input  logic [63:0] buf_rddata0,
   input  logic [63:0] buf_rddata1
);

   localparam logic [6:0] L_DM = 7'(CUBIC_D - 1);
   localparam logic [6:0] L_HM = 7'(CUBIC_D / 2 - 1);

   typedef enum logic {
      ST_WR = 1'b0,
      ST_RD = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [6:0]  r_row;
   logic [6:0]  r_col;
   logic [6:0]  r_dep;
   logic [6:0]  w_row_nxt;
   logic [6:0]  w_col_nxt;
   logic [6:0]  w_dep_nxt;
   logic        r_out_valid;
   logic [63:0] r_out_data0;
   logic [63:0] r_out_data1;
   logic        r_frame_done;
   logic        w_wr;
   logic        w_rd;
   logic        w_row_end;
   logic        w_col_end;
   logic        w_dep_end;
   logic        w_last;

   assign w_row_end = (r_row == L_HM);
   assign w_col_end = (r_col == L_DM);
   assign w_dep_end = (r_dep == L_DM);
   // Final index is the same corner for both traversal orders.
   assign w_last    = w_row_end & w_col_end & w_dep_end;

   // Strobes are gated by reset so nothing reaches the buffer while held.
   assign w_wr = reset_n & (r_state == ST_WR) & in_valid;
   assign w_rd = reset_n & (r_state == ST_RD) & (~r_out_valid | out_ready);

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_dep_nxt   = r_dep;
      unique case (r_state)
         ST_WR: begin
            if (w_wr) begin
               if (w_last) begin
                  w_state_nxt = ST_RD;
                  w_row_nxt   = '0;
                  w_col_nxt   = '0;
                  w_dep_nxt   = '0;
               end else if (!w_col_end) begin
                  w_col_nxt = r_col + 7'd1;
               end else begin
                  w_col_nxt = '0;
                  if (!w_dep_end) begin
                     w_dep_nxt = r_dep + 7'd1;
                  end else begin
                     w_dep_nxt = '0;
                     w_row_nxt = r_row + 7'd1;
                  end
               end
            end
         end
         ST_RD: begin
            if (w_rd) begin
               if (w_last) begin
                  w_state_nxt = ST_WR;
                  w_row_nxt   = '0;
                  w_col_nxt   = '0;
                  w_dep_nxt   = '0;
               end else if (!w_row_end) begin
                  w_row_nxt = r_row + 7'd1;
               end else begin
                  w_row_nxt = '0;
                  if (!w_col_end) begin
                     w_col_nxt = r_col + 7'd1;
                  end else begin
                     w_col_nxt = '0;
                     w_dep_nxt = r_dep + 7'd1;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_WR;
         r_row   <= '0;
         r_col   <= '0;
         r_dep   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_col   <= w_col_nxt;
         r_dep   <= w_dep_nxt;
      end
   end

   // Output register drains on its own, even after returning to WR.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid  <= 1'b0;
         r_out_data0  <= '0;
         r_out_data1  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_rd) begin
            r_out_valid <= 1'b1;
            r_out_data0 <= buf_rddata0;
            r_out_data1 <= buf_rddata1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         r_frame_done <= w_rd & w_last;
      end
   end

   assign in_ready    = (r_state == ST_WR);
   assign busy        = (r_state == ST_RD);
   assign buf_wr      = w_wr;
   assign buf_rd      = w_rd;
   assign buf_row     = (w_wr | w_rd) ? r_row : '0;
   assign buf_col     = (w_wr | w_rd) ? r_col : '0;
   assign buf_dep     = (w_wr | w_rd) ? r_dep : '0;
   assign buf_wrdata0 = in_data0;
   assign buf_wrdata1 = in_data1;
   assign out_valid   = r_out_valid;
   assign out_data0   = r_out_data0;
   assign out_data1   = r_out_data1;
   assign frame_done  = r_frame_done;

endmodule

// File: doc/buf_seq.md
# buf_seq

Frame sequencer for the 96×96×96 transpose buffer between two 1-D FFT passes of the 3-D FFT. It accepts two complex samples per cycle from the upstream FFT stage and drives the buffer's write and address ports in row/dep/col order. Once a full cube is stored, it drives the buffer's read port in the transposed order and presents the read data to the downstream stage through a one-entry valid/ready output register.

## Interface
Parameters:
- CUBIC_D, 96, cube edge length; must be even; row index counts row pairs 0..CUBIC_D/2-1.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  high in WR state.
- in_data0, in_data1  in  64 each  upstream sample pair (even, odd row).
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts the beat.
- out_data0, out_data1  out  64 each  registered read data.
- frame_done  out  1  one-cycle pulse after the last read is issued.
- busy  out  1  high in RD state.
- buf_wr, buf_rd  out  1 each  buffer write and read strobes.
- buf_row, buf_col, buf_dep  out  7 each  buffer index (row = row pair).
- buf_wrdata0, buf_wrdata1  out  64 each  equal in_data0 and in_data1.
- buf_rddata0, buf_rddata1  in  64 each  combinational buffer read data.

## Operation
- States: WR (reset state) and RD. The buffer is single-ported for addressing, so buf_wr and buf_rd are never high together.
- WR state:
  - in_ready=1 and buf_wr = in_valid.
  - buf_row/col/dep come from the write counters.
  - Write counter order: col fastest (0..CUBIC_D-1), then dep, then row (0..CUBIC_D/2-1).
  - Counters advance only on an accepted beat.
  - The beat at (CUBIC_D/2-1, CUBIC_D-1, CUBIC_D-1) moves the state to RD and clears all counters.
- RD state:
  - in_ready=0.
  - buf_rd = (!out_valid | out_ready).
  - buf_row/col/dep come from the read counters.
  - Read counter order: row fastest (0..CUBIC_D/2-1), then col, then dep.
  - On a clock edge with buf_rd=1: out_data0/1 <= buf_rddata0/1, out_valid <= 1, and the counters advance.
  - The read at (CUBIC_D/2-1, CUBIC_D-1, CUBIC_D-1) moves the state to WR, clears the counters, and registers frame_done=1 for the next cycle.
- Output register:
  - out_valid clears on out_valid & out_ready when no new read is captured.
  - It drains independently of the state; the final beat may still be pending during the next WR state.
- When neither state is reading or writing, buf_row/col/dep = 0.
- Arithmetic: the counters are 7-bit unsigned and wrap explicitly at their terminal values, never by overflow.
- Frame length: CUBIC_D³/2 beats in, CUBIC_D³/2 beats out (442368 each at the default CUBIC_D).

## Timing
- Reset (async, reset_n=0):
  - state=WR, all counters 0.
  - out_valid=0, out_data0/1=0, frame_done=0, busy=0.
  - Buffer contents are not touched.
- Reset release: in_ready=1 from the first edge onward.
- Write latency: 0; the data is written on the same edge that accepts it.
- Read latency:
  - buf_rd at cycle t gives out_valid and data at t+1.
  - With out_ready held high, throughput is 1 beat per cycle.
- Backpressure: when out_valid=1 and out_ready=0, buf_rd=0, and the counters and out_data hold. No beat is dropped or duplicated.
- Last write accepted at cycle t: RD state and busy=1 at t+1, first buf_rd at t+1.
- Last read at cycle t: WR state, in_ready=1, and frame_done=1 at t+1.
- reset_n asserted mid-frame: immediate return to the reset values; no frame_done; the partial frame is discarded.

## Test plan
- Run the bench with CUBIC_D=6 for speed; buffer model: mem[(2r+k)·D²+d·D+c] on write, mem[d·D²+c·D+2r+k] on read.
- Reset check: hold reset_n=0 with random inputs -> out_valid=0, frame_done=0, busy=0, in_ready=1, buf_wr=buf_rd=0.
- Full write, in_valid=1, beat k carries data0=2k, data1=2k+1:
  - beat 0 -> (row,col,dep)=(0,0,0); beat 1 -> (0,1,0); beat 6 -> (0,0,1); beat 36 -> (1,0,0).
  - beat 107 -> (2,5,5), then in_ready=0 and busy=1 next cycle.
- Full read, out_ready=1:
  - read addresses (0,0,0), (1,0,0), (2,0,0), (0,1,0), …
  - each out_data0/1 matches the model.
  - 108 beats total; frame_done is a single pulse the cycle after the 108th read.
  - in_ready=1 on that same cycle.
- Backpressure: drop out_ready for 10 cycles at read beat 40 -> out_data and the counters frozen, buf_rd=0; the stream resumes at beat 41 with no gap or duplicate.
- Input gaps: toggle in_valid 1010… during write -> counters advance only on high cycles, and the final addresses are the same as in the gap-free run.
- Mid-frame reset: assert reset_n=0 at read beat 50 -> out_valid=0 and state WR immediately. No frame_done pulse. After release, a fresh write starts at (0,0,0).
